reg_pipe: RTL
=============

REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into stage data on reset, flush or bubble.
REQ-004 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  advance enable; 0 stalls the whole pipe.
REQ-007 SHALL have port flush  input  1  synchronous invalidate of all stages.
REQ-008 SHALL have port in_valid  input  1  in_data qualifier.
REQ-009 SHALL have port in_data  input  WIDTH  data into stage 0.
REQ-010 SHALL have port out_valid  output  1  valid bit of stage DEPTH-1.
REQ-011 SHALL have port out_data  output  WIDTH  data of stage DEPTH-1.
REQ-012 SHALL have port occupancy  output  $clog2(DEPTH+1)  count of valid stages.
REQ-013 SHALL have port busy  output  1  high iff occupancy != 0.

Function
REQ-014 SHALL hold DEPTH stages, each a WIDTH-bit data register plus one valid bit.
REQ-015 On a clk rising edge with rst=0, flush=0, en=1: stage 0 SHALL load in_valid and (in_valid ? in_data : RESET_VAL); stage k SHALL load stage k-1 for k=1..DEPTH-1.
REQ-016 Output of stage DEPTH-1 SHALL be discarded on advance; no backpressure, no overflow indication.
REQ-017 With en=0 (rst=0, flush=0) all stages SHALL hold; in_valid/in_data ignored and lost.
REQ-018 Latency SHALL be exactly DEPTH enabled edges: item accepted at enabled edge n appears on out_valid/out_data after enabled edge n+DEPTH-1, stalled edges not counted.
REQ-019 out_valid/out_data SHALL be driven directly from stage DEPTH-1 registers (no combinational path from inputs).
REQ-020 Whenever out_valid=0, out_data SHALL equal RESET_VAL.
REQ-021 flush=1 at an edge (rst=0) SHALL clear all valid bits and set all stage data to RESET_VAL, regardless of en; in_valid on that edge is dropped.
REQ-022 Priority SHALL be rst > flush > en.
REQ-023 occupancy SHALL equal the population count of valid bits in the same cycle, range 0..DEPTH; registered or combinational, but never off by one at any edge.
REQ-024 Simultaneous accept and discard (in_valid=1, out_valid=1, en=1) SHALL leave occupancy unchanged.
REQ-025 DEPTH=1 SHALL behave as a single enabled register with valid and flush (latency 1).
REQ-026 Back-to-back valid items SHALL be accepted every enabled cycle with no bubbles inserted.

Reset
REQ-027 rst=1 at an edge SHALL clear all valid bits and set all stage data to RESET_VAL, regardless of en/flush.
REQ-028 After reset: out_valid=0, out_data=RESET_VAL, occupancy=0, busy=0.
REQ-029 Reset asserted mid-stream SHALL drop all in-flight items; no item accepted before reset appears afterward.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=0 unless noted)
REQ-030 Reset, en=1, in_valid=1, in_data=0xA5 one cycle then in_valid=0 -> out_valid=1, out_data=0xA5 exactly after 4th edge, one cycle wide; occupancy 1,1,1,1,0.
REQ-031 Stream 0x01..0x06 on consecutive edges, en=1 -> out_data 0x01..0x06 on consecutive cycles starting 4 edges after first; occupancy peaks at 4.
REQ-032 Load 0x11,0x22, drop en for 3 edges, restore -> outputs frozen while stalled; 0x11 emerges after 4 enabled edges total, 0x22 next cycle.
REQ-033 Fill pipe with 0x10..0x13 (occupancy=4), assert flush with en=0 and in_valid=1, in_data=0x99 -> next cycle occupancy=0, busy=0, out_valid=0, out_data=0x00; 0x99 never appears.
REQ-034 Fill with 2 items, assert rst and flush together with en=1 -> all cleared; then with RESET_VAL=0xFF build, idle out_data=0xFF.
REQ-035 DEPTH=1 build: 0x3C accepted -> out_valid=1, out_data=0x3C after one edge; en=0 holds it; flush clears it.

Source files
------------

// File: rtl/reg_pipe.sv
// Parameterised valid/data register pipeline with stall, flush and occupancy.
// Data leaves stage DEPTH-1 after exactly DEPTH enabled edges; there is no backpressure.
module reg_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       busy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] stage_vld;
  logic [WIDTH-1:0] stage_dat [DEPTH];
  logic [OCC_W-1:0] vld_count;

  // NOTE: the data registers are reset as well as the valid bits, because an
  // empty stage must read RESET_VAL; stage 0 loads RESET_VAL for bubbles so the
  // invariant then holds for every stage without extra output muxing.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its neighbour's pre-edge value and the shift happens in parallel.
      stage_vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stage_dat[k] <= RESET_VAL;
      end
    end else if (en) begin
      stage_vld[0] <= in_valid;
      stage_dat[0] <= in_valid ? in_data : RESET_VAL;
      for (int k = 1; k < DEPTH; k++) begin
        stage_vld[k] <= stage_vld[k-1];
        stage_dat[k] <= stage_dat[k-1];
      end
    end
  end

  // Population count of the valid bits; combinational so it can never lag an edge.
  always_comb begin
    // NOTE: the accumulator is given a value before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    vld_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      vld_count = vld_count + OCC_W'(stage_vld[k]);
    end
  end

  assign out_valid = stage_vld[DEPTH-1];
  assign out_data  = stage_dat[DEPTH-1];
  assign occupancy = vld_count;
  assign busy      = |stage_vld;

endmodule
